block_memory: RTL and testbench

BLOCK_MEMORY -- requirements
Module: block_memory

---
 rtl/block_memory.sv | 174 +++++++++++++++++
 tb/tb_block_memory.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/block_memory.sv
// Multi-cycle 64 x 32-bit block memory behind a cache miss handler.
// Optional access statistics are compiled in with `define BLOCK_MEMORY_STATS_EN.
module block_memory #(
  parameter int unsigned LATENCY = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [5:0]  mem_address,
  input  logic [31:0] mem_writedata,
  output logic [31:0] mem_readdata,
  output logic        mem_busywait
`ifdef BLOCK_MEMORY_STATS_EN
  ,
  output logic [15:0] read_count,
  output logic [15:0] write_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        op_write_q, op_write_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_q [64];
  logic [31:0] mem_d [64];

  logic req_valid;
  logic finish;

  // Read and write together is a malformed request and is never accepted.
  assign req_valid = mem_read ^ mem_write;
  assign finish    = (state_q == BUSY) && (cnt_q == LAT);

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // through the block leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = BUSY;
      BUSY:    if (finish)    state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Busywait is combinational so the cache stalls in the request cycle itself.
  always_comb begin
    mem_busywait = 1'b0;
    unique case (state_q)
      IDLE:    mem_busywait = req_valid;
      BUSY:    mem_busywait = 1'b1;
      DONE:    mem_busywait = 1'b0;
      default: mem_busywait = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------- request capture
  always_comb begin
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_write_d = op_write_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          cnt_d      = 4'd1;
          addr_d     = mem_address;
          wdata_d    = mem_writedata;
          op_write_d = mem_write;
        end
      end
      BUSY:    cnt_d = finish ? 4'd0 : cnt_q + 4'd1;
      DONE:    cnt_d = '0;
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      op_write_q <= op_write_d;
    end
  end

  // ---------------------------------------------------------------- storage
  // Only the captured request is used at completion, so address or data
  // changes on the ports after acceptance cannot disturb the access.
  always_comb begin
    mem_d   = mem_q;
    rdata_d = rdata_q;
    if (finish) begin
      if (op_write_q) begin
        mem_d[addr_q] = wdata_q;
      end else begin
        rdata_d = mem_q[addr_q];
      end
    end
  end

  // NOTE: the array is cleared on reset, which forces it into flops rather
  // than a RAM macro; the clear-on-reset contents are part of the behaviour.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_readdata = rdata_q;

`ifdef BLOCK_MEMORY_STATS_EN
  // ---------------------------------------------------------------- statistics
  logic [15:0] read_count_q, read_count_d;
  logic [15:0] write_count_q, write_count_d;

  always_comb begin
    read_count_d  = read_count_q;
    write_count_d = write_count_q;
    if (finish) begin
      if (op_write_q) write_count_d = write_count_q + 16'd1;
      else            read_count_d  = read_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      read_count_q  <= '0;
      write_count_q <= '0;
    end else begin
      read_count_q  <= read_count_d;
      write_count_q <= write_count_d;
    end
  end

  assign read_count  = read_count_q;
  assign write_count = write_count_q;
`endif

endmodule

// File: tb/tb_block_memory.sv
// Directed self-checking bench for block_memory at the default LATENCY of 5.
module tb_block_memory;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;
`ifdef BLOCK_MEMORY_STATS_EN
  logic [15:0] read_count;
  logic [15:0] write_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  block_memory dut (
    .clock         (clock),
    .reset         (reset),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
`ifdef BLOCK_MEMORY_STATS_EN
    ,
    .read_count    (read_count),
    .write_count   (write_count)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One cache-style access. After acceptance the port address/data switch to
  // post_a/post_d, and the request may be dropped while the access is busy.
  task automatic access(input bit is_wr, input logic [5:0] a, input logic [31:0] d,
                        input logic [5:0] post_a, input logic [31:0] post_d, input bit drop,
                        output int lat, output logic [31:0] rd, output int e0);
    int n;
    @(posedge clock); #1;
    mem_read      = !is_wr;
    mem_write     = is_wr;
    mem_address   = a;
    mem_writedata = d;
    @(negedge clock);
    check("busywait_rise", {31'd0, mem_busywait}, 32'd1);
    @(posedge clock); #1;
    e0            = cyc;
    mem_address   = post_a;
    mem_writedata = post_d;
    if (drop) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
    n = 0;
    @(negedge clock);
    while (mem_busywait && n < 40) begin
      @(posedge clock);
      n++;
      @(negedge clock);
    end
    if (n >= 40) check("busywait_timeout", 32'(n), 32'd0);
    lat       = n;
    rd        = mem_readdata;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
    int lat, e0;
    logic [31:0] rd;
    access(1'b0, a, 32'h0, a, 32'h0, 1'b0, lat, rd, e0);
    check({tag, "_lat"}, 32'(lat), 32'd5);
    check({tag, "_data"}, rd, exp);
  endtask

  task automatic wr_chk(input string tag, input logic [5:0] a, input logic [31:0] d);
    int lat, e0;
    logic [31:0] rd;
    access(1'b1, a, d, a, d, 1'b0, lat, rd, e0);
    check({tag, "_lat"}, 32'(lat), 32'd5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat_w, lat_r, e0_w, e0_r;
    logic [31:0] rd;

    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    mem_address = '0; mem_writedata = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_busywait", {31'd0, mem_busywait}, 32'd0);
    check("reset_readdata", mem_readdata, 32'h0);

    // Read of a cleared block: five busy cycles after acceptance.
    rd_chk("rd_2a", 6'h2A, 32'h0);

    // Write then read back-to-back; acceptance edges are LATENCY+2 apart.
    access(1'b1, 6'h15, 32'hDEADBEEF, 6'h15, 32'hDEADBEEF, 1'b0, lat_w, rd, e0_w);
    check("wr_15_lat", 32'(lat_w), 32'd5);
    check("wr_keeps_readdata", rd, 32'h0);
    access(1'b0, 6'h15, 32'h0, 6'h15, 32'h0, 1'b0, lat_r, rd, e0_r);
    check("rd_15_lat", 32'(lat_r), 32'd5);
    check("rd_15_data", rd, 32'hDEADBEEF);
    check("period", 32'(e0_r - e0_w), 32'd7);

    // Both strobes high is ignored for three cycles.
    @(posedge clock); #1;
    mem_read = 1'b1; mem_write = 1'b1; mem_address = 6'h15; mem_writedata = 32'hFFFF_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("both_busywait", {31'd0, mem_busywait}, 32'd0);
      @(posedge clock);
    end
    #1 mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clock);
    check("both_readdata_held", mem_readdata, 32'hDEADBEEF);
    rd_chk("rd_15_after_both", 6'h15, 32'hDEADBEEF);

    // Reset at E0+2 aborts a write and clears the whole array.
    @(posedge clock); #1;
    mem_write = 1'b1; mem_address = 6'h07; mem_writedata = 32'h12345678;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1; mem_write = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("abort_busywait", {31'd0, mem_busywait}, 32'd0);
    check("abort_readdata", mem_readdata, 32'h0);
    rd_chk("rd_07_after_abort", 6'h07, 32'h0);
    rd_chk("rd_15_after_reset", 6'h15, 32'h0);

    // Address and data change after acceptance do not redirect the write.
    access(1'b1, 6'h03, 32'hA5A5A5A5, 6'h3F, 32'h5A5A5A5A, 1'b0, lat_w, rd, e0_w);
    check("wr_03_lat", 32'(lat_w), 32'd5);
    rd_chk("rd_03", 6'h03, 32'hA5A5A5A5);
    rd_chk("rd_3f", 6'h3F, 32'h0);

    // Request dropped during BUSY still completes and commits.
    access(1'b1, 6'h3C, 32'h0BADF00D, 6'h3C, 32'h0BADF00D, 1'b1, lat_w, rd, e0_w);
    check("drop_lat", 32'(lat_w), 32'd5);
    check("drop_readdata_held", rd, 32'h0);
    rd_chk("rd_3c", 6'h3C, 32'h0BADF00D);

`ifdef BLOCK_MEMORY_STATS_EN
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("stats_reset_rd", {16'd0, read_count}, 32'd0);
    rd_chk("st_rd0", 6'h01, 32'h0);
    wr_chk("st_wr0", 6'h02, 32'h00000022);
    rd_chk("st_rd1", 6'h02, 32'h00000022);
    wr_chk("st_wr1", 6'h04, 32'h00000044);
    rd_chk("st_rd2", 6'h04, 32'h00000044);
    check("stats_read_count", {16'd0, read_count}, 32'd3);
    check("stats_write_count", {16'd0, write_count}, 32'd2);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("stats_clr_rd", {16'd0, read_count}, 32'd0);
    check("stats_clr_wr", {16'd0, write_count}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
